// File: rtl/amm_word_reader_if.sv
// Avalon-MM read-side signal bundle between amm_word_reader (master) and the
// memory-mapped slave. Signal names keep the reader's port naming.
interface amm_word_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] amm_address_o;
    logic                  amm_read_o;
    logic [DATA_WIDTH-1:0] amm_readdata_i;
    logic                  amm_readdatavalid_i;
    logic                  amm_waitrequest_i;

    modport master (
        output amm_address_o,
        output amm_read_o,
        input  amm_readdata_i,
        input  amm_readdatavalid_i,
        input  amm_waitrequest_i
    );

    modport slave (
        input  amm_address_o,
        input  amm_read_o,
        output amm_readdata_i,
        output amm_readdatavalid_i,
        output amm_waitrequest_i
    );
endinterface

// File: rtl/amm_word_reader.sv
// Avalon-MM burst-less read master: fetches length_i words from base_addr_i into a
// credit-limited show-ahead FIFO. Define AMM_READER_PERF_EN for the waitrequest stall counter.
module amm_word_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  run_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] length_i,
    output logic                  busy_o,
    output logic                  done_o,
    amm_word_reader_if.master     amm,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [15:0]           wait_cycles_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, len_q, issued_q, popped_q;
    logic [CW-1:0]         outstanding_q, count_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CW:0]           in_flight;
    logic                  run_acc, credit_ok, accept, push, pop, last_read, last_pop;

    // Stream handshake: a word transfers on every cycle with out_valid_o & out_ready_i;
    // once raised, out_valid_o and out_data_o hold until that transfer happens.
    assign run_acc   = (state_q == S_IDLE) && run_i;
    assign in_flight = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok = in_flight < (CW+1)'(FIFO_DEPTH);
    assign accept    = amm.amm_read_o && !amm.amm_waitrequest_i;
    // Returned data is only taken against a read we actually issued in this job.
    assign push      = amm.amm_readdatavalid_i && (state_q != S_IDLE) && (outstanding_q != '0);
    assign pop       = out_valid_o && out_ready_i;
    assign last_read = accept && (issued_q == len_q - ADDR_WIDTH'(1));
    assign last_pop  = pop && out_last_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run_i) state_d = (length_i == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (last_read) state_d = S_DRAIN;
            S_DRAIN: if (last_pop) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read request depends only on registered state, so it cannot move during a stall.
    always_comb begin
        amm.amm_read_o    = (state_q == S_ISSUE) && credit_ok;
        amm.amm_address_o = (state_q == S_ISSUE) ? base_q + issued_q : '0;
        busy_o            = (state_q != S_IDLE);
        done_o            = (state_q == S_DONE);
        out_valid_o       = (count_q != '0);
        out_data_o        = out_valid_o ? mem_q[rd_ptr_q] : '0;
        out_last_o        = out_valid_o && (popped_q == len_q - ADDR_WIDTH'(1));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            if (run_acc) begin
                base_q   <= base_addr_i;
                len_q    <= length_i;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (accept) issued_q <= issued_q + ADDR_WIDTH'(1);
                if (pop)    popped_q <= popped_q + ADDR_WIDTH'(1);
            end
            case ({accept, push})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= amm.amm_readdata_i;
    end

`ifdef AMM_READER_PERF_EN
    logic [15:0] wait_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            wait_q <= '0;
        else if (run_acc)
            wait_q <= '0;
        else if (amm.amm_read_o && amm.amm_waitrequest_i && (wait_q != 16'hFFFF))
            wait_q <= wait_q + 16'd1;
    end

    assign wait_cycles_o = wait_q;
`else
    assign wait_cycles_o = '0;
`endif

`ifndef SYNTHESIS
    a_rdv_has_outstanding: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(amm.amm_readdatavalid_i && (state_q != S_IDLE) && (outstanding_q == '0)))
        else $error("amm_word_reader: readdatavalid with no outstanding read");
`endif
endmodule

// File: tb/tb_amm_word_reader.sv
// Directed bench for amm_word_reader: a negedge slave/stream monitor logs traffic,
// and one task per scenario compares the logs against hand-computed values.
module tb_amm_word_reader;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
`ifdef AMM_READER_PERF_EN
    localparam logic [15:0] EXP_WAIT = 16'd5;
`else
    localparam logic [15:0] EXP_WAIT = 16'd0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          run_i;
    logic [AW-1:0] base_addr_i, length_i;
    logic          busy_o, done_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o, out_last_o, out_ready_i;
    logic [15:0]   wait_cycles_o;

    amm_word_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) amm_if ();

    amm_word_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i),
        .base_addr_i(base_addr_i), .length_i(length_i),
        .busy_o(busy_o), .done_o(done_o), .amm(amm_if),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i), .wait_cycles_o(wait_cycles_o)
    );

    // clock / cycle counter
    initial forever #5 clk_i = ~clk_i;
    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    int checks = 0, failures = 0;
    int run_cyc, acc_n, stall_idx = -1, stall_left = 0, resp_lat = 2;
    bit stalling;
    int read_hi_cnt, busy_cnt, done_cnt, done_cyc, first_acc_cyc, first_val_cyc;
    logic [15:0]   wait_at_done;
    logic [AW-1:0] addr_log[$];
    logic [DW-1:0] data_log[$];
    logic          last_log[$];
    logic [AW-1:0] stall_addr_q[$];
    logic          stall_rd_q[$];
    int            pend_due[$];
    logic [AW-1:0] pend_addr[$];
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] mk_word(input logic [AW-1:0] a);
        return {16'hCAFE, 38'd0, a};
    endfunction

    // slave model + stream/status monitor, all on the falling edge
    initial begin
        amm_if.amm_readdata_i      = '0;
        amm_if.amm_readdatavalid_i = 1'b0;
        amm_if.amm_waitrequest_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            amm_if.amm_readdatavalid_i = 1'b0;
            amm_if.amm_readdata_i      = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                amm_if.amm_readdatavalid_i = 1'b1;
                amm_if.amm_readdata_i      = mk_word(pend_addr[0]);
                void'(pend_due.pop_front());
                void'(pend_addr.pop_front());
            end
            amm_if.amm_waitrequest_i = 1'b0;
            if (stall_left > 0 && acc_n == stall_idx && (stalling || amm_if.amm_read_o)) begin
                stalling = 1'b1;
                stall_left--;
                amm_if.amm_waitrequest_i = 1'b1;
                stall_addr_q.push_back(amm_if.amm_address_o);
                stall_rd_q.push_back(amm_if.amm_read_o);
            end
            if (amm_if.amm_read_o) read_hi_cnt++;
            if (amm_if.amm_read_o && !amm_if.amm_waitrequest_i) begin
                if (acc_n == 0) first_acc_cyc = cyc;
                acc_n++;
                addr_log.push_back(amm_if.amm_address_o);
                pend_due.push_back(cyc + resp_lat);
                pend_addr.push_back(amm_if.amm_address_o);
            end
            if (out_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
            if (out_valid_o && out_ready_i) begin
                data_log.push_back(out_data_o);
                last_log.push_back(out_last_o);
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc     = cyc;
                wait_at_done = wait_cycles_o;
            end
        end
    end

    // driver tasks (inputs change 1 time unit after the rising edge)
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc_n = 0; read_hi_cnt = 0; busy_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_acc_cyc = -1; first_val_cyc = -1;
        stalling = 1'b0; wait_at_done = 16'hDEAD;
        addr_log.delete(); data_log.delete(); last_log.delete();
        stall_addr_q.delete(); stall_rd_q.delete(); exp_q.delete();
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] len);
        clear_logs();
        base_addr_i = base;
        length_i    = len;
        run_i       = 1'b1;
        run_cyc     = cyc;
        tick(1);
        run_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) break;
            tick(1);
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; run_i = 1'b0; out_ready_i = 1'b1;
        base_addr_i = '0; length_i = '0;
        clear_logs();
        tick(3);
        rst_n_i = 1'b1;
        tick(2);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (amm_if.amm_read_o !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", amm_if.amm_read_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        checks++; if (wait_cycles_o !== 16'd0) begin failures++; $display("FAIL reset_wait got=%0d exp=0", wait_cycles_o); end
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1; resp_lat = 2;
        start_job(10'h010, 10'd4);
        wait_done(100);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_word(10'h010 + 10'(i)));
        checks++; if (addr_log.size() !== 4) begin failures++; $display("FAIL basic_nreads got=%0d exp=4", addr_log.size()); end
        checks++; if (data_log.size() !== 4) begin failures++; $display("FAIL basic_nwords got=%0d exp=4", data_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== 10'h010 + 10'(i)) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, addr_log[i], 10'h010 + 10'(i)); end
        end
        for (int i = 0; i < 4 && i < data_log.size(); i++) begin
            checks++; if (data_log[i] !== exp_q[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, data_log[i], exp_q[i]); end
            checks++; if (last_log[i] !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, last_log[i], i == 3); end
        end
        checks++; if (first_acc_cyc !== run_cyc + 1) begin failures++; $display("FAIL basic_read_latency got=%0d exp=%0d", first_acc_cyc, run_cyc + 1); end
        checks++; if (first_val_cyc !== run_cyc + 4) begin failures++; $display("FAIL basic_valid_latency got=%0d exp=%0d", first_val_cyc, run_cyc + 4); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (wait_cycles_o !== 16'd0) begin failures++; $display("FAIL basic_wait got=%0d exp=0", wait_cycles_o); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        start_job(10'h3FE, 10'd4);
        wait_done(100);
        checks++; if (addr_log.size() !== 4) begin failures++; $display("FAIL wrap_nreads got=%0d exp=4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, addr_log[i], exp_a[i]); end
        end
        for (int i = 0; i < 4 && i < data_log.size(); i++) begin
            checks++; if (data_log[i] !== mk_word(exp_a[i])) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, data_log[i], mk_word(exp_a[i])); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL wrap_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_zero_len();
        start_job(10'h055, 10'd0);
        wait_done(20);
        checks++; if (read_hi_cnt !== 0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", read_hi_cnt); end
        checks++; if (done_cyc !== run_cyc + 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, run_cyc + 1); end
        checks++; if (busy_cnt !== 1) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=1", busy_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (data_log.size() !== 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", data_log.size()); end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        start_job(10'h040, 10'd20);
        tick(30);
        checks++; if (acc_n !== DEPTH) begin failures++; $display("FAIL bp_reads_held got=%0d exp=%0d", acc_n, DEPTH); end
        checks++; if (amm_if.amm_read_o !== 1'b0) begin failures++; $display("FAIL bp_read_low got=%b exp=0", amm_if.amm_read_o); end
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%b exp=1", out_valid_o); end
        out_ready_i = 1'b1;
        wait_done(300);
        for (int i = 0; i < 20; i++) exp_q.push_back(mk_word(10'h040 + 10'(i)));
        checks++; if (data_log.size() !== 20) begin failures++; $display("FAIL bp_nwords got=%0d exp=20", data_log.size()); end
        for (int i = 0; i < 20 && i < data_log.size(); i++) begin
            checks++; if (data_log[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, data_log[i], exp_q[i]); end
            checks++; if (last_log[i] !== (i == 19)) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, last_log[i], i == 19); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_waitrequest();
        stall_idx = 1; stall_left = 5;
        start_job(10'h020, 10'd4);
        wait_done(100);
        stall_idx = -1;
        checks++; if (stall_addr_q.size() !== 5) begin failures++; $display("FAIL wr_stall_len got=%0d exp=5", stall_addr_q.size()); end
        for (int i = 0; i < stall_addr_q.size(); i++) begin
            checks++; if (stall_addr_q[i] !== 10'h021 || stall_rd_q[i] !== 1'b1) begin
                failures++; $display("FAIL wr_stable[%0d] got addr=%h read=%b exp addr=021 read=1", i, stall_addr_q[i], stall_rd_q[i]);
            end
        end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== 10'h020 + 10'(i)) begin failures++; $display("FAIL wr_addr[%0d] got=%h exp=%h", i, addr_log[i], 10'h020 + 10'(i)); end
        end
        checks++; if (data_log.size() !== 4) begin failures++; $display("FAIL wr_nwords got=%0d exp=4", data_log.size()); end
        checks++; if (wait_at_done !== EXP_WAIT) begin failures++; $display("FAIL wr_wait_at_done got=%0d exp=%0d", wait_at_done, EXP_WAIT); end
        checks++; if (wait_cycles_o !== EXP_WAIT) begin failures++; $display("FAIL wr_wait_hold got=%0d exp=%0d", wait_cycles_o, EXP_WAIT); end
    endtask

    task automatic test_reset_midjob();
        resp_lat = 6;
        start_job(10'h200, 10'd8);
        for (int i = 0; i < 50; i++) begin
            if (acc_n >= 3) break;
            tick(1);
        end
        checks++; if (acc_n !== 3) begin failures++; $display("FAIL mid_outstanding got=%0d exp=3", acc_n); end
        rst_n_i = 1'b0;
        #1;
        checks++; if ({busy_o, done_o, amm_if.amm_read_o, out_valid_o, out_last_o} !== 5'b0) begin
            failures++; $display("FAIL mid_ctrl_zero got=%b exp=00000", {busy_o, done_o, amm_if.amm_read_o, out_valid_o, out_last_o});
        end
        checks++; if (amm_if.amm_address_o !== '0 || out_data_o !== '0) begin
            failures++; $display("FAIL mid_bus_zero got addr=%h data=%h exp=0", amm_if.amm_address_o, out_data_o);
        end
        tick(2);
        rst_n_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pend_due.size() == 0) break;
            tick(1);
        end
        tick(2);
        checks++; if (data_log.size() !== 0 || out_valid_o !== 1'b0) begin
            failures++; $display("FAIL mid_late_dropped got words=%0d valid=%b exp=0", data_log.size(), out_valid_o);
        end
        resp_lat = 2;
        start_job(10'h100, 10'd2);
        wait_done(100);
        checks++; if (addr_log.size() !== 2) begin failures++; $display("FAIL rerun_nreads got=%0d exp=2", addr_log.size()); end
        checks++; if (data_log.size() !== 2) begin failures++; $display("FAIL rerun_nwords got=%0d exp=2", data_log.size()); end
        for (int i = 0; i < 2 && i < data_log.size(); i++) begin
            checks++; if (data_log[i] !== mk_word(10'h100 + 10'(i))) begin failures++; $display("FAIL rerun_data[%0d] got=%h exp=%h", i, data_log[i], mk_word(10'h100 + 10'(i))); end
            checks++; if (last_log[i] !== (i == 1)) begin failures++; $display("FAIL rerun_last[%0d] got=%b exp=%b", i, last_log[i], i == 1); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rerun_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_waitrequest();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
